// File: rtl/mrelbp_ci_rn.sv
// mrelbp_ci_rn: MRELBP centre-intensity engine.
// Takes one (2R+1)-pixel column for each accepted cycle and builds a
// (2R+1)x(2R+1) window. For each complete window it emits bit_o = (C*N >= S),
// where C is the window centre and S is the window sum. It also counts the
// ones and zeros of each frame.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   done_i       column valid; a frame is a contiguous run of done_i=1
//   col_i        K pixels, row 0 in [DW-1:0], row K-1 at the MSBs
//   ready_o      high in IDLE/ACTIVE; columns offered while low are dropped
//   bit_valid_o  CI result valid (2 cycles after the completing column)
//   bit_o        CI bit
//   done_o       one-cycle frame-complete pulse
//   bit_one_o    ones count of the last completed frame
//   bit_zero_o   zeros count of the last completed frame
module mrelbp_ci_rn #(
  parameter int unsigned R     = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 16,
  parameter int unsigned IMG_W = 640
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done_i,
  input  logic [(2*R+1)*DW-1:0]     col_i,
  output logic                      ready_o,
  output logic                      bit_valid_o,
  output logic                      bit_o,
  output logic                      done_o,
  output logic [CW-1:0]             bit_one_o,
  output logic [CW-1:0]             bit_zero_o
);

  localparam int unsigned K   = 2 * R + 1;
  localparam int unsigned N   = K * K;
  localparam int unsigned CSW = DW + $clog2(K);
  localparam int unsigned SW  = DW + $clog2(N);
  localparam int unsigned IW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH1,
    S_FLUSH2,
    S_REPORT
  } state_t;

  state_t state, state_n;

  logic [K*DW-1:0] win  [K];
  logic [CSW-1:0]  csum [K];
  logic [SW-1:0]   s_sum, s_next;
  logic [CSW-1:0]  cs_new;
  logic [IW-1:0]   col_idx;
  logic            accept, frame_start;

  logic            p1_valid;
  logic            p2_valid;
  logic [SW-1:0]   p2_cn, p2_s;
  logic            ci;

  logic [CW-1:0]   cnt_one, cnt_zero;

  assign ready_o     = (state == S_IDLE) || (state == S_ACTIVE);
  assign accept      = done_i && ready_o;
  assign frame_start = accept && (state == S_IDLE);
  assign ci          = (p2_cn >= p2_s);

  always_comb begin
    cs_new = '0;
    for (int unsigned i = 0; i < K; i++)
      cs_new = cs_new + CSW'(col_i[i*DW +: DW]);
  end

  // Running window sum. At column 0 of a row the previous row's sum is
  // discarded. The column that leaves the window is subtracted only once a
  // full K columns of this row are present. Before that, csum[K-1] still
  // holds a column from the previous row.
  always_comb begin
    s_next = (col_idx == '0) ? '0 : s_sum;
    s_next = s_next + SW'(cs_new);
    if (col_idx >= IW'(K))
      s_next = s_next - SW'(csum[K-1]);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (done_i) state_n = S_ACTIVE;
      S_ACTIVE: if (!done_i) state_n = S_FLUSH1;
      S_FLUSH1: state_n = S_FLUSH2;
      S_FLUSH2: state_n = S_REPORT;
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Stage 1: window shift, column index, running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < K; i++) begin
        win[i]  <= '0;
        csum[i] <= '0;
      end
      s_sum    <= '0;
      col_idx  <= '0;
      p1_valid <= 1'b0;
    end else begin
      p1_valid <= 1'b0;
      if (accept) begin
        win[0]  <= col_i;
        csum[0] <= cs_new;
        for (int unsigned i = 1; i < K; i++) begin
          win[i]  <= win[i-1];
          csum[i] <= csum[i-1];
        end
        s_sum    <= s_next;
        p1_valid <= (col_idx >= IW'(K - 1));
        col_idx  <= (col_idx == IW'(IMG_W - 1)) ? '0 : col_idx + 1'b1;
      end else if (state == S_ACTIVE && !done_i) begin
        col_idx <= '0;
      end
    end
  end

  // Stage 2: scale the centre and capture the sum. The window registers have
  // already shifted, so win[R] holds the column accepted R columns before
  // the newest one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p2_valid <= 1'b0;
      p2_cn    <= '0;
      p2_s     <= '0;
    end else begin
      p2_valid <= p1_valid;
      p2_cn    <= SW'(win[R][R*DW +: DW]) * SW'(N);
      p2_s     <= s_sum;
    end
  end

  // Stage 3: compare, output, frame counters and report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_valid_o <= 1'b0;
      bit_o       <= 1'b0;
      done_o      <= 1'b0;
      bit_one_o   <= '0;
      bit_zero_o  <= '0;
      cnt_one     <= '0;
      cnt_zero    <= '0;
    end else begin
      bit_valid_o <= p2_valid;
      bit_o       <= p2_valid && ci;
      done_o      <= (state == S_REPORT);
      if (frame_start) begin
        cnt_one  <= '0;
        cnt_zero <= '0;
      end else if (p2_valid) begin
        if (ci && (cnt_one != '1))         cnt_one  <= cnt_one + 1'b1;
        else if (!ci && (cnt_zero != '1))  cnt_zero <= cnt_zero + 1'b1;
      end
      if (state == S_REPORT) begin
        bit_one_o  <= cnt_one;
        bit_zero_o <= cnt_zero;
      end
    end
  end

endmodule

// File: tb/tb_mrelbp_ci_rn.sv
// Directed testbench for mrelbp_ci_rn.
// Instance a: R=2, IMG_W=8, CW=16. Instance b: R=2, IMG_W=40, CW=4, which
// exercises counter saturation.
module tb_mrelbp_ci_rn;

  logic        clk;
  logic        rst;

  logic        a_done, a_ready, a_bv, a_bit, a_done_o;
  logic [39:0] a_col;
  logic [15:0] a_one, a_zero;

  logic        b_done, b_ready, b_bv, b_bit, b_done_o;
  logic [39:0] b_col;
  logic [3:0]  b_one, b_zero;

  int unsigned n_checks;
  int unsigned n_fail;

  int unsigned colv [64];
  bit          expb [64];

  mrelbp_ci_rn #(.R(2), .DW(8), .CW(16), .IMG_W(8)) dut_a (
    .clk(clk), .rst(rst), .done_i(a_done), .col_i(a_col), .ready_o(a_ready),
    .bit_valid_o(a_bv), .bit_o(a_bit), .done_o(a_done_o),
    .bit_one_o(a_one), .bit_zero_o(a_zero)
  );

  mrelbp_ci_rn #(.R(2), .DW(8), .CW(4), .IMG_W(40)) dut_b (
    .clk(clk), .rst(rst), .done_i(b_done), .col_i(b_col), .ready_o(b_ready),
    .bit_valid_o(b_bv), .bit_o(b_bit), .done_o(b_done_o),
    .bit_one_o(b_one), .bit_zero_o(b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk_col(input int unsigned v);
    logic [39:0] c;
    for (int i = 0; i < 5; i++) c[i*8 +: 8] = v[7:0];
    return c;
  endfunction

  // Drives n columns from colv[] into instance a, then idles. The cycle
  // after the first done_i=0 (FLUSH), it can optionally offer one extra
  // column. Column k is driven after posedge k and sampled on posedge k+1,
  // so its window result is visible in iteration k+3. The first done_i=0 is
  // sampled on posedge n+1, and done_o becomes visible in iteration n+4.
  task automatic run_frame(input string name, input int n, input int unsigned exp_one,
                           input int unsigned exp_zero, input bit inject_drop);
    int wi;
    bit ev;
    wi = 0;
    for (int k = 0; k < n + 8; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        a_done = 1'b1; a_col = mk_col(colv[k]);
      end else if (inject_drop && k == n + 1) begin
        a_done = 1'b1; a_col = '1;
      end else begin
        a_done = 1'b0; a_col = '0;
      end
      @(negedge clk);
      check_val($sformatf("%s ready k=%0d", name, k), 32'(a_ready),
                32'(!(k >= n + 1 && k <= n + 3)));
      ev = (k >= 3) && (k - 3 < n) && (((k - 3) % 8) >= 4);
      check_val($sformatf("%s bit_valid k=%0d", name, k), 32'(a_bv), 32'(ev));
      if (ev) begin
        check_val($sformatf("%s bit w%0d", name, wi), 32'(a_bit), 32'(expb[wi]));
        wi++;
      end
      check_val($sformatf("%s done_o k=%0d", name, k), 32'(a_done_o), 32'(k == n + 4));
      if (k == n + 4) begin
        check_val($sformatf("%s bit_one", name), 32'(a_one), exp_one);
        check_val($sformatf("%s bit_zero", name), 32'(a_zero), exp_zero);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    bit seen_done;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    a_done = 1'b0; a_col = '0;
    b_done = 1'b0; b_col = '0;

    #12;
    check_val("reset ready", 32'(a_ready), 32'd1);
    check_val("reset bit_valid", 32'(a_bv), 32'd0);
    check_val("reset bit", 32'(a_bit), 32'd0);
    check_val("reset done_o", 32'(a_done_o), 32'd0);
    check_val("reset bit_one", 32'(a_one), 32'd0);
    check_val("reset bit_zero", 32'(a_zero), 32'd0);
    rst = 1'b1;

    // Flat frame: every window has 10*25 = 250 >= 250.
    for (int i = 0; i < 8; i++) colv[i] = 10;
    for (int i = 0; i < 4; i++) expb[i] = 1'b1;
    run_frame("flat", 8, 4, 0, 1'b0);

    // Column gradient: S = 750,750,700,600 and C = 30,40,50,10.
    colv[0] = 10; colv[1] = 20; colv[2] = 30; colv[3] = 40;
    colv[4] = 50; colv[5] = 10; colv[6] = 10; colv[7] = 10;
    expb[0] = 1'b1; expb[1] = 1'b1; expb[2] = 1'b1; expb[3] = 1'b0;
    run_frame("grad", 8, 3, 1, 1'b0);

    // Zero case: C = 10, S = 5*(40+100) = 700, and 250 < 700.
    colv[0] = 10; colv[1] = 10; colv[2] = 10; colv[3] = 10; colv[4] = 100;
    expb[0] = 1'b0;
    run_frame("zero", 5, 0, 1, 1'b0);

    // Row wrap: 16 flat columns give two rows of 4 windows each.
    for (int i = 0; i < 16; i++) colv[i] = 10;
    for (int i = 0; i < 8; i++) expb[i] = 1'b1;
    run_frame("wrap", 16, 8, 0, 1'b0);

    // A frame shorter than K still reports.
    for (int i = 0; i < 3; i++) colv[i] = 10;
    run_frame("short", 3, 0, 0, 1'b0);

    // A column offered during FLUSH is dropped.
    for (int i = 0; i < 8; i++) colv[i] = 10;
    for (int i = 0; i < 4; i++) expb[i] = 1'b1;
    run_frame("drop", 8, 4, 0, 1'b1);

    // Reset mid-frame, at a point where bit_valid_o is high.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      a_done = 1'b1; a_col = mk_col(10);
      @(negedge clk);
    end
    check_val("prerst bit_valid", 32'(a_bv), 32'd1);
    check_val("prerst bit_one", 32'(a_one), 32'd4);
    #2 rst = 1'b0;
    #1;
    check_val("midrst bit_valid", 32'(a_bv), 32'd0);
    check_val("midrst bit", 32'(a_bit), 32'd0);
    check_val("midrst done_o", 32'(a_done_o), 32'd0);
    check_val("midrst bit_one", 32'(a_one), 32'd0);
    check_val("midrst bit_zero", 32'(a_zero), 32'd0);
    check_val("midrst ready", 32'(a_ready), 32'd1);
    a_done = 1'b0; a_col = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val($sformatf("postrst done_o k=%0d", k), 32'(a_done_o), 32'd0);
      check_val($sformatf("postrst bit_valid k=%0d", k), 32'(a_bv), 32'd0);
    end
    colv[0] = 10; colv[1] = 20; colv[2] = 30; colv[3] = 40;
    colv[4] = 50; colv[5] = 10; colv[6] = 10; colv[7] = 10;
    expb[0] = 1'b1; expb[1] = 1'b1; expb[2] = 1'b1; expb[3] = 1'b0;
    run_frame("fresh", 8, 3, 1, 1'b0);

    // Saturation on instance b: 36 windows, but a 4-bit ones count stops at 15.
    nb = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(posedge clk); #1;
      b_done = (k < 40);
      b_col  = (k < 40) ? mk_col(10) : '0;
      @(negedge clk);
      if (b_bv) nb++;
      if (b_done_o) seen_done = 1'b1;
    end
    check_val("sat windows", 32'(nb), 32'd36);
    check_val("sat done_o seen", 32'(seen_done), 32'd1);
    check_val("sat bit_one", 32'(b_one), 32'd15);
    check_val("sat bit_zero", 32'(b_zero), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
